// File: rtl/nibble_loader.sv
// Operand entry front end: debounces the write/clear buttons and turns each accepted
// write press into a one-cycle nibble write, assembling the 8-slot word for display.
module nibble_loader_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0, sync_p1;
    logic             vld_p0, vld_p1;
    logic [CNT_W-1:0] cnt;
    logic             level, level_q;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            armed   <= 1'b0;
            evt     <= 1'b0;
        end else begin
            // synchronizer stage, with a valid bit marking when sync_p1 reflects real input
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;

            // a button held through reset must be seen released before it can fire
            if (vld_p1 && !sync_p1)
                armed <= 1'b1;

            // debounce stage
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // edge stage
            level_q <= level;
            evt     <= level & ~level_q & armed;
        end
    end
endmodule

module nibble_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SLOTS           = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_wr,
    input  logic                     btn_clr,
    input  logic [3:0]               data_in,
    output logic                     wr_en,
    output logic [$clog2(SLOTS)-1:0] ptr,
    output logic [3:0]               nib_out,
    output logic [4*SLOTS-1:0]       word,
    output logic                     full
);
    localparam int PTR_W = $clog2(SLOTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_FULL
    } state_t;

    state_t state;
    logic   wr_evt;
    logic   clr_evt;

    nibble_loader_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_wr (
        .clk (clk),
        .rst (rst),
        .raw (btn_wr),
        .evt (wr_evt)
    );

    nibble_loader_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clr (
        .clk (clk),
        .rst (rst),
        .raw (btn_clr),
        .evt (clr_evt)
    );

    // output register stage; clear outranks a simultaneous write
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_en   <= 1'b0;
            ptr     <= '0;
            nib_out <= '0;
            word    <= '0;
            full    <= 1'b0;
        end else if (clr_evt) begin
            state   <= S_IDLE;
            wr_en   <= 1'b0;
            ptr     <= '0;
            nib_out <= '0;
            word    <= '0;
            full    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_evt && !full) begin
                        nib_out                <= data_in;
                        word[{ptr, 2'b00} +: 4] <= data_in;
                        wr_en                  <= 1'b1;
                        state                  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    wr_en <= 1'b0;
                    if (ptr == PTR_LAST) begin
                        ptr   <= '0;
                        full  <= 1'b1;
                        state <= S_FULL;
                    end else begin
                        ptr   <= ptr + PTR_W'(1);
                        state <= S_IDLE;
                    end
                end
                S_FULL: begin
                    wr_en <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_loader.sv
// Directed-plus-random bench for nibble_loader, checked against a slot-array model of
// the operand entry rules (latency, pointer order, full/clear/reset behaviour).
module tb_nibble_loader;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_wr;
    logic        btn_clr;
    logic [3:0]  data_in;
    logic        wr_en;
    logic [2:0]  ptr;
    logic [3:0]  nib_out;
    logic [31:0] word;
    logic        full;

    nibble_loader #(
        .DEBOUNCE_CYCLES(D),
        .SLOTS(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_wr  (btn_wr),
        .btn_clr (btn_clr),
        .data_in (data_in),
        .wr_en   (wr_en),
        .ptr     (ptr),
        .nib_out (nib_out),
        .word    (word),
        .full    (full)
    );

    always #5 clk = ~clk;

    int compares = 0;
    int fails    = 0;

    int          cyc = 0;
    int          strobes = 0;
    int          consec = 0;
    int          last_cyc = 0;
    logic [2:0]  last_ptr = '0;
    logic [3:0]  last_nib = '0;
    logic [31:0] last_word = '0;
    logic        prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            strobes   = strobes + 1;
            last_cyc  = cyc;
            last_ptr  = ptr;
            last_nib  = nib_out;
            last_word = word;
            if (prev_wr === 1'b1) consec = consec + 1;
        end
        prev_wr = wr_en;
    end

    // reference model: the operand as an array of slots plus a write cursor
    logic [3:0] m_slot [8];
    int         m_ptr;
    bit         m_full;

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        for (int k = 0; k < 8; k++) w = w | (32'(m_slot[k]) << (4 * k));
        return w;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_slot[k] = '0;
        m_ptr  = 0;
        m_full = 0;
    endtask

    task automatic model_write(input logic [3:0] nib);
        if (!m_full) begin
            m_slot[m_ptr] = nib;
            if (m_ptr == 7) begin
                m_ptr  = 0;
                m_full = 1;
            end else begin
                m_ptr = m_ptr + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ptr"}, 32'(ptr), 32'(m_ptr));
        check({tag, "_word"}, word, model_word());
        check({tag, "_full"}, 32'(full), 32'(m_full));
    endtask

    task automatic press_wr(input logic [3:0] nib, input int hold);
        int  n0;
        int  t0;
        bit  expect_w;
        int  exp_ptr;
        n0       = strobes;
        expect_w = !m_full;
        exp_ptr  = m_ptr;
        data_in  = nib;
        btn_wr   = 1'b1;
        t0       = cyc;
        repeat (D + 6) tick();
        data_in = 4'($urandom);
        repeat (hold - (D + 6)) tick();
        btn_wr = 1'b0;
        repeat (D + 6) tick();
        if (expect_w) model_write(nib);
        check("wr_strobes", 32'(strobes - n0), expect_w ? 32'd1 : 32'd0);
        if (expect_w) begin
            check("wr_latency", 32'(last_cyc - t0), 32'(D + 4));
            check("wr_ptr", 32'(last_ptr), 32'(exp_ptr));
            check("wr_nib", 32'(last_nib), 32'(nib));
            check("wr_word_at_strobe", last_word, model_word());
        end
        check_state("after_wr");
    endtask

    task automatic press_clr(input int hold);
        int n0;
        n0      = strobes;
        btn_clr = 1'b1;
        repeat (hold) tick();
        btn_clr = 1'b0;
        repeat (D + 6) tick();
        model_clear();
        check("clr_strobes", 32'(strobes - n0), 32'd0);
        check("clr_nib", 32'(nib_out), 32'd0);
        check_state("after_clr");
    endtask

    initial begin
        bit         seen;
        int         n0;
        logic [3:0] nib;

        model_clear();
        rst     = 1'b1;
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        data_in = 4'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_nib", 32'(nib_out), 32'd0);
        check_state("rst");
        n0 = strobes;
        repeat (100) tick();
        check("idle_no_strobe", 32'(strobes - n0), 32'd0);

        // single press, then fill from an empty operand with 1..8
        press_wr(4'hA, 20);
        check("first_word", word, 32'h0000_000A);
        press_clr(D + 8);
        for (int i = 1; i <= 8; i++) press_wr(4'(i), D + 8 + i);
        check("fill_word", word, 32'h8765_4321);
        check("fill_full", 32'(full), 32'd1);
        press_wr(4'hF, D + 10);

        // clear and write raised together after three writes
        press_clr(D + 7);
        for (int i = 0; i < 3; i++) press_wr(4'($urandom), $urandom_range(D + 6, D + 16));
        n0      = strobes;
        data_in = 4'($urandom);
        btn_wr  = 1'b1;
        btn_clr = 1'b1;
        repeat (D + 10) tick();
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        repeat (D + 6) tick();
        model_clear();
        check("both_strobes", 32'(strobes - n0), 32'd0);
        check_state("both");

        // glitch trains shorter than the debounce window
        press_wr(4'($urandom), D + 9);
        n0 = strobes;
        for (int i = 0; i < 10; i++) begin
            btn_wr = 1'b1;
            repeat (3) tick();
            btn_wr = 1'b0;
            repeat (2) tick();
        end
        for (int i = 0; i < 8; i++) begin
            btn_wr = 1'b1;
            repeat ($urandom_range(1, D - 1)) tick();
            btn_wr = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
        end
        repeat (D + 6) tick();
        check("glitch_strobes", 32'(strobes - n0), 32'd0);
        check_state("glitch");

        // random presses and clears against the model, crossing the full boundary
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 6) == 0) press_clr($urandom_range(D + 4, D + 12));
            else press_wr(4'($urandom), $urandom_range(D + 6, D + 20));
        end

        // reset while the strobe is up and the button is still held
        press_clr(D + 6);
        nib     = 4'($urandom);
        data_in = nib;
        btn_wr  = 1'b1;
        seen    = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (wr_en === 1'b1) seen = 1;
        end
        check("pulse_seen", 32'(seen), 32'd1);
        model_write(nib);
        rst = 1'b1;
        tick();
        model_clear();
        check("rst_pulse_wr_en", 32'(wr_en), 32'd0);
        check("rst_pulse_nib", 32'(nib_out), 32'd0);
        check_state("rst_pulse");
        rst = 1'b0;
        n0  = strobes;
        repeat (40) tick();
        check("held_after_rst", 32'(strobes - n0), 32'd0);
        btn_wr = 1'b0;
        repeat (D + 6) tick();
        press_wr(4'($urandom), D + 8);

        check("no_back_to_back", 32'(consec), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule

// File: doc/nibble_loader.md
Name: nibble_loader

Overview:
- Operand entry front end for the RSA sequential datapath: turns raw board buttons and a 4-bit data switch bank into clean single-cycle nibble writes toward the datapath's nibble-write interface (data, write enable, 3-bit slot pointer).
- Pointer auto-increments across 8 slots; the assembled 32-bit word is mirrored for the seven-segment display path so the operator sees what was keyed in.
- Writer side of the nibble-write interface: the datapath consumes, this block produces.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a button level is accepted (5 ms at 100 MHz); legal range >= 2; benches override to 4.
- SLOTS, 8, number of nibble slots; fixed at 8 (ptr width 3, word width 32).

Ports:
- clk  in  1  system clock, undivided.
- rst  in  1  synchronous, active-high reset.
- btn_wr  in  1  raw write push-button, asynchronous to clk.
- btn_clr  in  1  raw clear push-button, asynchronous to clk.
- data_in  in  4  nibble switch bank, sampled at the write event.
- wr_en  out  1  one-cycle write strobe to the datapath.
- ptr  out  3  slot index accompanying wr_en.
- nib_out  out  4  nibble accompanying wr_en.
- word  out  32  assembled operand; slot k occupies bits [4k+3:4k].
- full  out  1  high once all 8 slots are written.

Behaviour:
- Reset (rst high at a clk edge): wr_en=0, ptr=0, nib_out=0, word=0, full=0, FSM=IDLE, synchronizers and debounce counters cleared, debounced levels=0. Reset mid-press: the held button is not accepted until it has been seen low-then-high again after reset.
- Input conditioning, per button: 2-flop synchronizer, then a counter that resets whenever the synchronized level differs from the accepted level. When the count reaches DEBOUNCE_CYCLES, the accepted level takes the new value. An event fires for one cycle when the accepted level rises; a falling accepted level fires nothing.
- Pulses shorter than DEBOUNCE_CYCLES produce no event. A held button produces exactly one event.
- Latency: a clean raw rising edge held steady produces wr_en exactly DEBOUNCE_CYCLES+4 clk cycles later (2 sync, DEBOUNCE_CYCLES count, 1 edge, 1 output register).
- FSM states and transitions:
  - IDLE
    - On wr event with full=0: capture data_in into nib_out, go to PULSE.
    - On wr event with full=1: ignored, remain in current state.
  - PULSE
    - wr_en=1 for exactly one cycle with ptr = current slot and nib_out = captured nibble.
    - word[4*ptr+3:4*ptr] updated on the same edge wr_en rises.
    - Next cycle: wr_en=0. If ptr was 7, go to FULL with full=1 and ptr wrapped to 0. Otherwise ptr+1, back to IDLE.
  - FULL
    - wr events ignored; outputs held.
- Clear event, from any state: ptr=0, word=0, full=0, wr_en=0, nib_out=0, next state IDLE.
  - Clear during PULSE aborts the strobe on the following cycle; the already-issued cycle stands.
  - Clear and wr events on the same cycle: clear wins, no write issued.
- wr_en is never high on two consecutive cycles. ptr, nib_out and word are stable whenever wr_en=0.
- data_in changes outside the capture cycle have no effect.

Test Plan:
- rst held 3 cycles, then released -> all outputs 0; FSM in IDLE; no wr_en for 100 cycles with buttons low.
- DEBOUNCE_CYCLES=4; data_in=4'hA; btn_wr high 20 cycles -> single wr_en exactly 8 cycles after the raw edge, ptr=0, nib_out=A, word=32'h0000000A.
- DEBOUNCE_CYCLES=4; eight presses of data_in=1..8 with releases between -> ptr sequence 0..7; word=32'h87654321; full=1 after the 8th strobe; a 9th press -> no wr_en, word unchanged.
- Glitch train on btn_wr: 3-cycle high pulses, 2-cycle gaps, for 50 cycles -> zero wr_en strobes.
- btn_clr and btn_wr raised on the same cycle after 3 writes -> no wr_en; ptr=0, word=0, full=0.
- rst asserted in PULSE with btn_wr still held -> outputs 0 next edge; no further strobe until btn_wr is released and pressed again.
